// File: rtl/opb_select_stage.sv
`default_nettype none
// ============================================================================
//  Module      : opb_select_stage
//  Description : Registered operand-B selector. Picks one of N_SRC full-width
//                channels or the extended immediate, and hands it to the
//                execute stage over valid/ready through a 2-entry skid buffer.
//                Build option: define OPB_SIGN_EXT_EN to sign-extend the
//                immediate; otherwise it is zero-extended.
//  Revision    : 1.0 - initial release
// ============================================================================
module opb_select_stage #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 11,
    parameter int N_SRC  = 2,
    parameter int SEL_W  = $clog2(N_SRC + 2)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [SEL_W-1:0]        i_selB,
    input  logic [N_SRC*DATA_W-1:0] i_SRC,
    input  logic [IMM_W-1:0]        i_SIGNAL,
    output logic [DATA_W-1:0]       o_MUL_B,
    output logic [SEL_W-1:0]        o_src,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_err
);

    // Buffer occupancy: bit 1 = main register full, bit 0 = skid entry full.
    localparam logic [1:0] c_EMPTY = 2'b00;
    localparam logic [1:0] c_ONE   = 2'b10;
    localparam logic [1:0] c_FULL  = 2'b11;

    // Select code that picks the immediate; anything above it is illegal.
    localparam logic [SEL_W-1:0] c_IMM_SEL = SEL_W'(N_SRC);

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_main_data;
    logic [SEL_W-1:0]  r_main_src;
    logic [DATA_W-1:0] r_skid_data;
    logic [SEL_W-1:0]  r_skid_src;
    logic              r_err;

    logic [DATA_W-1:0] w_imm_ext;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_illegal;
    logic              w_accept;

    // Immediate widening; a full-width immediate needs no extension at all.
    generate
        if (IMM_W == DATA_W) begin : g_imm_pass
            assign w_imm_ext = i_SIGNAL;
        end else begin : g_imm_ext
`ifdef OPB_SIGN_EXT_EN
            assign w_imm_ext = {{(DATA_W-IMM_W){i_SIGNAL[IMM_W-1]}}, i_SIGNAL};
`else
            assign w_imm_ext = {{(DATA_W-IMM_W){1'b0}}, i_SIGNAL};
`endif
        end
    endgenerate

    // Input-side operand mux; illegal codes yield zero and raise a flag.
    always_comb begin
        w_sel_data    = '0;
        w_sel_illegal = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (i_selB == SEL_W'(k)) begin
                w_sel_data = i_SRC[k*DATA_W +: DATA_W];
            end
        end
        if (i_selB == c_IMM_SEL) begin
            w_sel_data = w_imm_ext;
        end else if (i_selB > c_IMM_SEL) begin
            w_sel_illegal = 1'b1;
        end
    end

    // Ready depends only on the skid flop, so it is a registered signal.
    assign o_ready  = ~r_state[0];
    assign o_valid  = r_state[1];
    assign o_MUL_B  = r_main_data;
    assign o_src    = r_main_src;
    assign o_err    = r_err;
    assign w_accept = i_valid & o_ready;

    // Skid-buffer control: main register feeds the output, skid absorbs one
    // beat of back-pressure; data registers only change when a beat lands.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= c_EMPTY;
            r_main_data <= '0;
            r_main_src  <= '0;
            r_skid_data <= '0;
            r_skid_src  <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept && w_sel_illegal) begin
                r_err <= 1'b1;
            end
            case (r_state)
                c_EMPTY: begin
                    if (w_accept) begin
                        r_main_data <= w_sel_data;
                        r_main_src  <= i_selB;
                        r_state     <= c_ONE;
                    end
                end
                c_ONE: begin
                    if (i_ready) begin
                        if (w_accept) begin
                            r_main_data <= w_sel_data;
                            r_main_src  <= i_selB;
                        end else begin
                            r_state <= c_EMPTY;
                        end
                    end else if (w_accept) begin
                        r_skid_data <= w_sel_data;
                        r_skid_src  <= i_selB;
                        r_state     <= c_FULL;
                    end
                end
                c_FULL: begin
                    if (i_ready) begin
                        r_main_data <= r_skid_data;
                        r_main_src  <= r_skid_src;
                        r_state     <= c_ONE;
                    end
                end
                default: r_state <= c_EMPTY;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/opb_select_stage.md
Name: opb_select_stage

Overview:
- Parametrised, registered successor to the BIP operand-B selector.
- Selects operand B from N_SRC full-width data channels or from an extended immediate, and registers the result.
- Delivers the result to the ALU/multiplier stage over a valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops an operand.
- Sits between decode/data-memory read and the execute stage.

Parameters:
- DATA_W, 16: operand width.
- IMM_W, 11: immediate (i_SIGNAL) width; must satisfy 1 <= IMM_W <= DATA_W.
- N_SRC, 2: number of full-width source channels on i_SRC; must be >= 1.
- SEL_W, $clog2(N_SRC+2): select width (derived; do not override).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  upstream presents a selection this cycle.
- o_ready  out  1  stage can accept; registered, equals !skid_valid.
- i_selB  in  SEL_W  source select: 0..N_SRC-1 = channel k of i_SRC; N_SRC = extended immediate; > N_SRC = illegal.
- i_SRC  in  N_SRC*DATA_W  packed channels; channel k = bits [k*DATA_W +: DATA_W].
- i_SIGNAL  in  IMM_W  immediate field.
- o_MUL_B  out  DATA_W  selected operand, registered.
- o_src  out  SEL_W  i_selB value that produced o_MUL_B.
- o_valid  out  1  o_MUL_B/o_src valid.
- i_ready  in  1  downstream accepts this cycle.
- o_err  out  1  sticky illegal-select flag.

Behaviour:
- Reset (i_reset=1 at edge):
  - o_valid=0, o_MUL_B=0, o_src=0, o_err=0, o_ready=1.
  - Skid entry is emptied.
  - Reset wins over every simultaneous event; in-flight data is discarded.
- Accept: i_valid && o_ready at an edge. Transfer: o_valid && i_ready at an edge.
- Selection is combinational on the input side and captured at accept:
  - sel < N_SRC: channel sel.
  - sel == N_SRC: immediate extended to DATA_W (see Optional Feature).
  - sel > N_SRC: value 0, o_err set to 1 on the same edge; o_err stays 1 until reset. The beat is still accepted and delivered.
- Latency: 1 cycle. An accepted beat appears on o_MUL_B/o_valid the cycle after acceptance when the main register is free.
- Buffer states (main, skid):
  - EMPTY (0,0): accept loads main -> ONE.
  - ONE (1,0), cases:
    - Transfer without accept -> EMPTY.
    - Transfer with accept: main reloads -> ONE.
    - Accept without transfer: beat goes to skid -> FULL.
  - FULL (1,1): o_ready=0, so no accept is possible.
    - Transfer: skid moves to main -> ONE.
    - No transfer: hold.
- Ordering is strict FIFO; no beat is duplicated or lost.
- i_valid while o_ready=0 is ignored; upstream must hold it.
- o_MUL_B/o_src stay stable while o_valid && !i_ready.
- When not valid, o_MUL_B holds its last value; it reads 0 after reset.
- Inputs other than i_valid are don't-care when i_valid=0.
- IMM_W == DATA_W: immediate passes through unchanged; extension logic is absent.

Optional Feature:
- Macro: OPB_SIGN_EXT_EN.
- Defined: immediate is sign-extended; bit IMM_W-1 is replicated into bits [DATA_W-1:IMM_W].
- Undefined: immediate is zero-extended. This is the original BIP behaviour.
- Channel selection, illegal select and handshake behaviour are identical either way.

Test Plan (DATA_W=16, IMM_W=11, N_SRC=2, SEL_W=2):
- Reset/basic select:
  - Hold i_reset 2 cycles: o_valid=0, o_MUL_B=16'h0000, o_ready=1, o_err=0.
  - Then sel=0, i_SRC={16'h001F,16'hF800}, i_valid=1, i_ready=1.
  - Next cycle: o_MUL_B=16'hF800, o_src=0, o_valid=1.
- Immediate extension: sel=2, i_SIGNAL=11'h41F.
  - OPB_SIGN_EXT_EN defined: o_MUL_B=16'hFC1F.
  - Undefined: o_MUL_B=16'h041F.
  - With 11'h01F: 16'h001F in both builds.
- Back-pressure:
  - i_ready=0; present sel=1 then sel=0 on consecutive cycles.
  - o_ready drops to 0 after the second accept; o_MUL_B holds 16'h001F.
  - Raise i_ready: 16'h001F, then 16'hF800 transfer in order.
  - o_ready returns to 1 one cycle after the first transfer.
- Illegal select: sel=3, i_valid=1.
  - Next cycle: o_MUL_B=16'h0000, o_src=3, o_valid=1, o_err=1.
  - o_err stays 1 across later legal beats until i_reset.
- Reset mid-operation:
  - Fill to FULL with i_ready=0, then pulse i_reset one cycle.
  - Required: o_valid=0, o_ready=1, skid empty.
  - Subsequent transfers contain only post-reset beats.
- Streaming:
  - i_valid=i_ready=1 every cycle, sel alternating 0/1 for 8 beats.
  - Required: one transfer per cycle, o_ready constantly 1, output sequence F800,001F,... with 1-cycle latency.
